// File: rtl/dmem_sramlike_bridge.sv
// dmem_sramlike_bridge
//   Purpose : converts one memory-stage load/store into exactly one SRAM-like
//             transaction (req / addr_ok / data_ok), returns load data and
//             stalls the pipeline until that transaction retires. Also applies
//             the fixed kseg0/kseg1 virtual-to-physical mapping.
//   Latency : mem_en -> DONE is 3 cycles minimum (IDLE, REQ, DONE) when
//             addr_ok and data_ok both arrive in the first REQ cycle.
//   Backpressure: request is held in REQ until addr_ok; stall_by_dram stays
//             high through REQ/WAIT and drops for exactly the DONE cycle.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-low reset
//   i_mem_en/wr/sel/addr/wdata  memory-stage access (sel = byte lanes)
//   o_mem_rdata            raw 32-bit load data, updated on load completion
//   o_stall_by_dram        pipeline stall request
//   o_data_req/wr/size/addr/wdata  SRAM-like request side (physical address)
//   i_data_addr_ok         request accepted this cycle
//   i_data_data_ok         read data valid / write done this cycle
//   i_data_rdata           read data, valid with i_data_data_ok

module dmem_sramlike_bridge #(
   parameter int unsigned KSEG_MAP = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_en,
   input  logic        i_mem_wr,
   input  logic [3:0]  i_mem_sel,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   output logic [31:0] o_mem_rdata,
   output logic        o_stall_by_dram,
   output logic        o_data_req,
   output logic        o_data_wr,
   output logic [1:0]  o_data_size,
   output logic [31:0] o_data_addr,
   output logic [31:0] o_data_wdata,
   input  logic        i_data_addr_ok,
   input  logic        i_data_data_ok,
   input  logic [31:0] i_data_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_data_wr;
   logic [1:0]  r_data_size;
   logic [31:0] r_data_addr;
   logic [31:0] r_data_wdata;
   logic [31:0] r_mem_rdata;

   logic        w_latch;
   logic        w_complete;
   logic [1:0]  w_size;
   logic        w_in_kseg01;
   logic [31:0] w_phys_addr;
   logic [31:0] w_req_addr;

   // ------------------------------------------------------------------
   // Access size from byte lanes. Patterns the pipeline never produces
   // fall back to a word access.
   // ------------------------------------------------------------------
   always_comb begin
      w_size = 2'd2;
      case (i_mem_sel)
         4'b1111:                            w_size = 2'd2;
         4'b0011, 4'b1100:                   w_size = 2'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
         default:                            w_size = 2'd2;
      endcase
   end

   // ------------------------------------------------------------------
   // kseg0 (0x8000_0000..0x9FFF_FFFF) and kseg1 (0xA000_0000..0xBFFF_FFFF)
   // both map onto physical 0x0000_0000..0x1FFF_FFFF by dropping addr[31:29].
   // Word accesses are forced to a word-aligned address.
   // ------------------------------------------------------------------
   assign w_in_kseg01 = (KSEG_MAP != 0) && (i_mem_addr[31:30] == 2'b10);
   assign w_phys_addr = w_in_kseg01 ? {3'b000, i_mem_addr[28:0]} : i_mem_addr;
   assign w_req_addr  = (w_size == 2'd2) ? {w_phys_addr[31:2], 2'b00} : w_phys_addr;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state. data_ok is only honoured once the request has been
   // accepted (same cycle as addr_ok, or in WAIT); anything earlier is a
   // protocol violation and is ignored. mem_en is only looked at in IDLE,
   // so a flush mid-transaction never abandons an accepted/pending request.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_mem_en) begin
               w_latch     = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (i_data_addr_ok) begin
               if (i_data_data_ok) begin
                  w_complete  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (i_data_data_ok) begin
               w_complete  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // One cycle only; a new access is not accepted here.
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request registers: captured once on entry to REQ and held unchanged
   // until the next access is accepted.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_data_wr    <= 1'b0;
         r_data_size  <= 2'd0;
         r_data_addr  <= 32'd0;
         r_data_wdata <= 32'd0;
      end else if (w_latch) begin
         r_data_wr    <= i_mem_wr;
         r_data_size  <= w_size;
         r_data_addr  <= w_req_addr;
         r_data_wdata <= i_mem_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Load data: only a completing load updates it; stores leave the last
   // load value in place.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_mem_rdata <= 32'd0;
      end else if (w_complete && !r_data_wr) begin
         r_mem_rdata <= i_data_rdata;
      end
   end

   // ------------------------------------------------------------------
   // Outputs. Stall is combinational from mem_en in IDLE so the very first
   // cycle of an access already holds the pipeline.
   // ------------------------------------------------------------------
   assign o_data_req      = (r_state == S_REQ);
   assign o_data_wr       = r_data_wr;
   assign o_data_size     = r_data_size;
   assign o_data_addr     = r_data_addr;
   assign o_data_wdata    = r_data_wdata;
   assign o_mem_rdata     = r_mem_rdata;
   assign o_stall_by_dram = ((r_state == S_IDLE) && i_mem_en) ||
                            (r_state == S_REQ) ||
                            (r_state == S_WAIT);

endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// tb_dmem_sramlike_bridge
//   Driver issues memory-stage accesses and queues the expected SRAM-like
//   request; a responder plays the downstream converter with random
//   addr_ok/data_ok delays and queues expected timing and load data; a
//   monitor checks handshakes and completions against those queues.

module tb_dmem_sramlike_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en;
   logic        mem_wr;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall;
   logic        req;
   logic        dwr;
   logic [1:0]  dsize;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   dmem_sramlike_bridge #(.KSEG_MAP(1)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_mem_en       (mem_en),
      .i_mem_wr       (mem_wr),
      .i_mem_sel      (mem_sel),
      .i_mem_addr     (mem_addr),
      .i_mem_wdata    (mem_wdata),
      .o_mem_rdata    (mem_rdata),
      .o_stall_by_dram(stall),
      .o_data_req     (req),
      .o_data_wr      (dwr),
      .o_data_size    (dsize),
      .o_data_addr    (daddr),
      .o_data_wdata   (dwdata),
      .i_data_addr_ok (addr_ok),
      .i_data_data_ok (data_ok),
      .i_data_rdata   (rdata)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      int          req_cycles;
      int          stall_cycles;
      logic [31:0] rdata;
   } rsp_t;

   req_t exp_req_q[$];
   rsp_t rsp_q[$];

   int checks = 0;
   int errors = 0;
   int issued = 0;
   int retired = 0;

   // Responder controls (negative = random)
   int          force_a = -1;
   int          force_d = -1;
   bit          force_rd = 1'b0;
   logic [31:0] forced_rdata = 32'd0;
   bit          stale_mode = 1'b0;
   bit          allow_spur = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] ref_size(input logic [3:0] sel);
      int n;
      n = $countones(sel);
      if (sel == 4'b1111) return 2'd2;
      if (sel == 4'b0011 || sel == 4'b1100) return 2'd1;
      if (n == 1) return 2'd0;
      return 2'd2;
   endfunction

   function automatic logic [31:0] ref_addr(input logic [31:0] va, input logic [3:0] sel);
      logic [31:0] pa;
      pa = va;
      if (va >= 32'h8000_0000 && va < 32'hC000_0000) pa = va % 32'h2000_0000;
      if (ref_size(sel) == 2'd2) pa = (pa / 4) * 4;
      return pa;
   endfunction

   // ---------------- driver helpers ----------------
   task automatic idle_gap(input int n);
      mem_en = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Presents one access and returns at +1 after the edge entering DONE.
   task automatic issue(input logic wr, input logic [3:0] sel, input logic [31:0] va,
                        input logic [31:0] wd, input bit drop);
      req_t r;
      int   n;
      r.wr    = wr;
      r.size  = ref_size(sel);
      r.addr  = ref_addr(va, sel);
      r.wdata = wd;
      exp_req_q.push_back(r);
      issued++;
      mem_en    = 1'b1;
      mem_wr    = wr;
      mem_sel   = sel;
      mem_addr  = va;
      mem_wdata = wd;
      n = 0;
      do begin
         @(posedge clk); #1;
         if (drop && n == 0) mem_en = 1'b0;
         n++;
         if (n > 60) begin
            $display("FAIL completion_timeout: stall still %b after %0d cycles", stall, n);
            $fatal(1, "bridge never completed");
         end
      end while (stall);
   endtask

   // ---------------- responder (downstream converter) ----------------
   initial begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      rdata   = 32'd0;
      forever begin
         int          a;
         int          d;
         bit          stale;
         logic [31:0] rd;
         rsp_t        rs;
         do begin
            @(posedge clk); #1;
         end while (!req);
         a     = (force_a >= 0) ? force_a : int'($urandom_range(0, 3));
         d     = (force_d >= 0) ? force_d : int'($urandom_range(0, 3));
         stale = stale_mode;
         rd    = force_rd ? forced_rdata : $urandom;
         for (int i = 0; i < a; i++) begin
            // Early data_ok before acceptance must be ignored by the bridge.
            if (allow_spur && $urandom_range(0, 3) == 0) begin
               data_ok = 1'b1;
               rdata   = $urandom;
            end
            @(posedge clk); #1;
            data_ok = 1'b0;
         end
         addr_ok = 1'b1;
         if (d == 0) begin
            data_ok = 1'b1;
            rdata   = rd;
         end
         @(posedge clk); #1;
         addr_ok = 1'b0;
         data_ok = 1'b0;
         if (d > 0) begin
            for (int i = 0; i < d - 1; i++) begin
               @(posedge clk); #1;
            end
            data_ok = 1'b1;
            rdata   = rd;
            @(posedge clk); #1;
            data_ok = 1'b0;
         end
         if (!stale) begin
            rs.req_cycles   = a + 1;
            rs.stall_cycles = a + 2 + d;
            rs.rdata        = rd;
            rsp_q.push_back(rs);
         end
      end
   end

   // ---------------- monitor ----------------
   bit          prev_stall = 1'b0;
   bit          hs_pending = 1'b0;
   int          stall_cnt = 0;
   int          req_cnt = 0;
   logic [31:0] model_rdata = 32'd0;
   req_t        cur;

   always @(negedge clk) begin
      rsp_t rs;
      if (!rst) begin
         prev_stall  = 1'b0;
         hs_pending  = 1'b0;
         stall_cnt   = 0;
         req_cnt     = 0;
         model_rdata = 32'd0;
      end else begin
         if (stall) stall_cnt++;
         if (req) req_cnt++;
         if (req && addr_ok) begin
            chk("single_outstanding", {31'd0, hs_pending}, 32'd0);
            if (exp_req_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_request: addr %h with none pending", daddr);
            end else begin
               cur = exp_req_q.pop_front();
               chk("req_wr",    {31'd0, dwr},   {31'd0, cur.wr});
               chk("req_size",  {30'd0, dsize}, {30'd0, cur.size});
               chk("req_addr",  daddr,          cur.addr);
               chk("req_wdata", dwdata,         cur.wdata);
               hs_pending = 1'b1;
            end
         end
         if (prev_stall && !stall) begin
            chk("done_after_accept", {31'd0, hs_pending}, 32'd1);
            chk("no_req_in_done", {31'd0, req}, 32'd0);
            if (rsp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: no response recorded");
            end else begin
               rs = rsp_q.pop_front();
               chk("req_cycles",   req_cnt,   rs.req_cycles);
               chk("stall_cycles", stall_cnt, rs.stall_cycles);
               if (!cur.wr) model_rdata = rs.rdata;
               chk("mem_rdata", mem_rdata, model_rdata);
            end
            retired++;
            hs_pending = 1'b0;
            stall_cnt  = 0;
            req_cnt    = 0;
         end
         prev_stall = stall;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main stimulus ----------------
   logic [3:0]  sel_tab [8];
   logic [31:0] base_tab [4];

   initial begin
      sel_tab  = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5};
      base_tab = '{32'h0000_0000, 32'h8000_0000, 32'hA000_0000, 32'hC000_0000};
      rst       = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_sel   = 4'h0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req",    {31'd0, req},   32'd0);
      chk("rst_wr",     {31'd0, dwr},   32'd0);
      chk("rst_size",   {30'd0, dsize}, 32'd0);
      chk("rst_addr",   daddr,          32'd0);
      chk("rst_wdata",  dwdata,         32'd0);
      chk("rst_rdata",  mem_rdata,      32'd0);
      chk("rst_stall",  {31'd0, stall}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;

      // Word load through kseg0, addr_ok after 2 cycles, data 3 cycles later.
      force_a = 2; force_d = 3; force_rd = 1'b1; forced_rdata = 32'hDEAD_BEEF;
      issue(1'b0, 4'hF, 32'h8000_0010, 32'h1234_5678, 1'b0);
      chk("load_rdata_done", mem_rdata, 32'hDEAD_BEEF);
      force_rd = 1'b0;

      // Byte store through kseg1, back-to-back behind the load.
      force_a = 1; force_d = 1;
      issue(1'b1, 4'b0100, 32'hBFC0_0003, 32'h0055_0000, 1'b0);
      chk("store_keeps_rdata", mem_rdata, 32'hDEAD_BEEF);

      // addr_ok and data_ok together in the first REQ cycle.
      idle_gap(1);
      force_a = 0; force_d = 0;
      issue(1'b0, 4'h3, 32'h0000_1002, 32'h0, 1'b0);

      // mem_en dropped right after REQ entry: transaction still completes.
      idle_gap(1);
      force_a = 3; force_d = 2;
      issue(1'b0, 4'hC, 32'h9000_0106, 32'h0, 1'b1);

      // Back-to-back loads with mem_en held across DONE.
      idle_gap(1);
      force_a = -1; force_d = -1;
      issue(1'b0, 4'hF, 32'h8000_0200, 32'h0, 1'b0);
      issue(1'b0, 4'hF, 32'h8000_0204, 32'h0, 1'b0);

      // Reset while in WAIT; the stale data_ok later must be ignored.
      idle_gap(1);
      force_a = 0; force_d = 6; stale_mode = 1'b1;
      begin
         req_t r;
         r.wr = 1'b0; r.size = 2'd2; r.addr = 32'h0000_0100; r.wdata = 32'h0;
         exp_req_q.push_back(r);
      end
      mem_en = 1'b1; mem_wr = 1'b0; mem_sel = 4'hF; mem_addr = 32'h8000_0100; mem_wdata = 32'h0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b0;
      mem_en = 1'b0;
      #1;
      chk("arst_req",   {31'd0, req},   32'd0);
      chk("arst_wr",    {31'd0, dwr},   32'd0);
      chk("arst_size",  {30'd0, dsize}, 32'd0);
      chk("arst_addr",  daddr,          32'd0);
      chk("arst_rdata", mem_rdata,      32'd0);
      chk("arst_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("stale_stall", {31'd0, stall}, 32'd0);
         chk("stale_req",   {31'd0, req},   32'd0);
         chk("stale_rdata", mem_rdata,      32'd0);
      end
      stale_mode = 1'b0;
      force_a = -1; force_d = -1;

      // Randomized traffic.
      allow_spur = 1'b1;
      for (int t = 0; t < 150; t++) begin
         int          g;
         bit          drop;
         logic [31:0] va;
         g    = int'($urandom_range(0, 2));
         drop = (g > 0) && ($urandom_range(0, 7) == 0);
         va   = base_tab[$urandom_range(0, 3)] + ($urandom & 32'h1FFF_FFFF);
         idle_gap(g);
         issue(1'($urandom_range(0, 1)), sel_tab[$urandom_range(0, 7)], va, $urandom, drop);
      end
      idle_gap(4);

      chk("all_retired", retired, issued);
      chk("req_queue_empty", exp_req_q.size(), 0);
      chk("rsp_queue_empty", rsp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
